// File: rtl/wb_conbus_n.sv
// Wishbone shared-bus interconnect: N masters, M slaves, registered round-robin
// arbiter, MSB address decode, and bus-error generation for unmapped/timeout.
module wb_conbus_n #(
  parameter int                        N_M        = 6,
  parameter int                        N_S        = 9,
  parameter int                        DW         = 32,
  parameter int                        AW         = 32,
  parameter int                        S_ADDR_W   = 4,
  parameter logic [N_S*S_ADDR_W-1:0]   S_ADDR_MAP = 36'h876543210,
  parameter int                        TIMEOUT    = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [N_M*DW-1:0]     m_dat_i,
  output logic [DW-1:0]         m_dat_o,
  input  logic [N_M*AW-1:0]     m_adr_i,
  input  logic [N_M*3-1:0]      m_cti_i,
  input  logic [N_M*DW/8-1:0]   m_sel_i,
  input  logic [N_M-1:0]        m_we_i,
  input  logic [N_M-1:0]        m_cyc_i,
  input  logic [N_M-1:0]        m_stb_i,
  output logic [N_M-1:0]        m_ack_o,
  output logic [N_M-1:0]        m_err_o,
  input  logic [N_S*DW-1:0]     s_dat_i,
  output logic [DW-1:0]         s_dat_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [2:0]            s_cti_o,
  output logic [DW/8-1:0]       s_sel_o,
  output logic                  s_we_o,
  output logic [N_S-1:0]        s_cyc_o,
  output logic [N_S-1:0]        s_stb_o,
  input  logic [N_S-1:0]        s_ack_i
);
  localparam int SW = DW / 8;
  localparam int PW = (N_M > 1) ? $clog2(N_M) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {E_IDLE, E_WAIT, E_ERR} err_e;

  logic [N_M-1:0] r_gnt, w_gnt_n;
  logic [PW-1:0]  r_ptr, w_ptr_n, w_idx;
  logic           w_found;
  err_e           r_st, w_st_n;
  logic [CW-1:0]  r_cnt, w_cnt_n;

  logic           w_gcyc, w_gstb, w_hit, w_sack, w_we;
  logic [N_S-1:0] w_sel;
  logic [AW-1:0]  w_adr;
  logic [DW-1:0]  w_dat, w_rdat;
  logic [2:0]     w_cti;
  logic [SW-1:0]  w_bsel;

  // Grant is one-hot, so OR-ing the masked master buses is a clean mux.
  always_comb begin
    w_adr  = '0;
    w_dat  = '0;
    w_cti  = '0;
    w_bsel = '0;
    w_we   = 1'b0;
    for (int k = 0; k < N_M; k++) begin
      if (r_gnt[k]) begin
        w_adr  = w_adr  | m_adr_i[k*AW +: AW];
        w_dat  = w_dat  | m_dat_i[k*DW +: DW];
        w_cti  = w_cti  | m_cti_i[k*3 +: 3];
        w_bsel = w_bsel | m_sel_i[k*SW +: SW];
        w_we   = w_we   | m_we_i[k];
      end
    end
  end

  assign w_gcyc = |(r_gnt & m_cyc_i);
  assign w_gstb = |(r_gnt & m_stb_i);

  // Re-arbitrate only when nobody holds the bus, which locks bursts and RMW.
  always_comb begin
    w_gnt_n = r_gnt;
    w_ptr_n = r_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    if (!w_gcyc) begin
      w_gnt_n = '0;
      for (int i = 1; i <= N_M; i++) begin
        w_idx = PW'((int'(r_ptr) + i) % N_M);
        if (!w_found && m_cyc_i[w_idx]) begin
          w_found          = 1'b1;
          w_gnt_n          = '0;
          w_gnt_n[w_idx]   = 1'b1;
          w_ptr_n          = w_idx;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_gnt <= '0;
      r_ptr <= PW'(N_M - 1);
    end else begin
      r_gnt <= w_gnt_n;
      r_ptr <= w_ptr_n;
    end
  end

  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int k = 0; k < N_S; k++) begin
      if (!w_hit && w_adr[AW-1 -: S_ADDR_W] == S_ADDR_MAP[k*S_ADDR_W +: S_ADDR_W]) begin
        w_sel[k] = 1'b1;
        w_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    w_rdat = '0;
    for (int k = 0; k < N_S; k++)
      if (w_sel[k]) w_rdat = w_rdat | s_dat_i[k*DW +: DW];
  end

  assign w_sack = |(s_ack_i & w_sel);

  // Losing the grant or the strobe abandons the wait without raising an error.
  always_comb begin
    w_st_n  = r_st;
    w_cnt_n = r_cnt;
    case (r_st)
      E_IDLE: begin
        if (w_gcyc && w_gstb && !w_sack) begin
          w_st_n  = w_hit ? E_WAIT : E_ERR;
          w_cnt_n = '0;
        end
      end
      E_WAIT: begin
        if (!w_gcyc || !w_gstb || w_sack) begin
          w_st_n  = E_IDLE;
          w_cnt_n = '0;
        end else if (TIMEOUT != 0 && r_cnt == CW'(TIMEOUT - 1)) begin
          w_st_n  = E_ERR;
          w_cnt_n = '0;
        end else if (TIMEOUT != 0) begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        w_st_n  = E_IDLE;
        w_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_st  <= E_IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_n;
      r_cnt <= w_cnt_n;
    end
  end

  assign s_adr_o = w_adr;
  assign s_dat_o = w_dat;
  assign s_cti_o = w_cti;
  assign s_sel_o = w_bsel;
  assign s_we_o  = w_we;
  assign s_cyc_o = {N_S{w_gcyc}} & w_sel;
  assign s_stb_o = {N_S{w_gcyc & w_gstb & (r_st != E_ERR)}} & w_sel;
  assign m_dat_o = w_rdat;
  assign m_ack_o = {N_M{w_sack}} & r_gnt;
  assign m_err_o = {N_M{(r_st == E_ERR) & ~w_sack}} & r_gnt;
endmodule

// File: tb/tb_wb_conbus_n.sv
// Bench for wb_conbus_n: 6 masters, 9 slaves, TIMEOUT=8. Vector table for
// decode/mux/ack/unmapped-err, plus hand sequences for arbitration and timeouts.
module tb_wb_conbus_n;
  localparam int N_M = 6, N_S = 9, DW = 32, AW = 32, TO = 8;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b1;
  logic [N_M*DW-1:0]   m_dat_i = '0;
  logic [DW-1:0]       m_dat_o;
  logic [N_M*AW-1:0]   m_adr_i = '0;
  logic [N_M*3-1:0]    m_cti_i = '0;
  logic [N_M*DW/8-1:0] m_sel_i = '0;
  logic [N_M-1:0]      m_we_i  = '0;
  logic [N_M-1:0]      m_cyc_i = '0;
  logic [N_M-1:0]      m_stb_i = '0;
  logic [N_M-1:0]      m_ack_o, m_err_o;
  logic [N_S*DW-1:0]   s_dat_i = '0;
  logic [DW-1:0]       s_dat_o;
  logic [AW-1:0]       s_adr_o;
  logic [2:0]          s_cti_o;
  logic [DW/8-1:0]     s_sel_o;
  logic                s_we_o;
  logic [N_S-1:0]      s_cyc_o, s_stb_o, s_ack_i;
  logic                ack_auto = 1'b0;
  logic [N_S-1:0]      ack_vec  = '0;

  // Zero-wait slaves when ack_auto is set, otherwise an explicit ack pattern.
  assign s_ack_i = ack_auto ? s_stb_o : ack_vec;

  always #5 sys_clk = ~sys_clk;

  wb_conbus_n #(.N_M(N_M), .N_S(N_S), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_adr_i(m_adr_i), .m_cti_i(m_cti_i),
    .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
    .s_adr_o(s_adr_o), .s_cti_o(s_cti_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i)
  );

  typedef enum int {SG_STB, SG_CYC, SG_ACK, SG_ERR, SG_RDAT, SG_ADR, SG_WE, SG_WDAT} sig_e;
  typedef struct { string name; sig_e sig; logic [63:0] exp; } chk_t;
  typedef struct {
    logic [31:0] adr; logic we; logic [8:0] ack; logic [8:0] stb;
    logic [5:0] mack; logic [31:0] dat; logic err;
  } vec_t;

  chk_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] sdat(input int k);
    return (k == 3) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(k));
  endfunction

  function automatic logic [31:0] mdat(input int k, input logic [31:0] a);
    return a ^ 32'h5A5A5A5A ^ 32'(k);
  endfunction

  function automatic logic [63:0] sample(input sig_e s);
    case (s)
      SG_STB:  return 64'(s_stb_o);
      SG_CYC:  return 64'(s_cyc_o);
      SG_ACK:  return 64'(m_ack_o);
      SG_ERR:  return 64'(m_err_o);
      SG_RDAT: return 64'(m_dat_o);
      SG_ADR:  return 64'(s_adr_o);
      SG_WE:   return 64'(s_we_o);
      default: return 64'(s_dat_o);
    endcase
  endfunction

  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", n, a, e);
    end
  endtask

  task automatic push(input string n, input sig_e s, input logic [63:0] e);
    chk_t c;
    c.name = n; c.sig = s; c.exp = e;
    sb.push_back(c);
  endtask

  // Compare queued expectations mid-cycle, then move just past the next edge.
  task automatic step();
    chk_t c;
    @(negedge sys_clk);
    while (sb.size() > 0) begin
      c = sb.pop_front();
      cmp(c.name, sample(c.sig), c.exp);
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [2:0] cti, input logic [31:0] adr);
    m_cyc_i[k] = cyc;
    m_stb_i[k] = stb;
    m_we_i[k]  = we;
    m_cti_i[k*3 +: 3]   = cti;
    m_adr_i[k*AW +: AW] = adr;
    m_dat_i[k*DW +: DW] = mdat(k, adr);
    m_sel_i[k*4 +: 4]   = 4'hF;
  endtask

  task automatic idle_all(input int n);
    for (int k = 0; k < N_M; k++) set_m(k, 1'b0, 1'b0, 1'b0, 3'b000, 32'(k) << 28);
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t vt[8];

  initial begin
    int exp_g[$];
    int down, acked, beats;

    for (int k = 0; k < N_S; k++) s_dat_i[k*DW +: DW] = sdat(k);
    vt[0] = '{32'h3000_0010, 1'b0, 9'h008, 9'h008, 6'h01, 32'hDEADBEEF, 1'b0};
    vt[1] = '{32'h0000_0004, 1'b1, 9'h001, 9'h001, 6'h01, sdat(0),      1'b0};
    vt[2] = '{32'h8000_0000, 1'b0, 9'h100, 9'h100, 6'h01, sdat(8),      1'b0};
    vt[3] = '{32'h5000_0000, 1'b1, 9'h020, 9'h020, 6'h01, sdat(5),      1'b0};
    vt[4] = '{32'h2000_0000, 1'b0, 9'h001, 9'h004, 6'h00, sdat(2),      1'b0};
    vt[5] = '{32'h7000_0000, 1'b0, 9'h1FF, 9'h080, 6'h01, sdat(7),      1'b0};
    vt[6] = '{32'hF000_0000, 1'b0, 9'h1FF, 9'h000, 6'h00, 32'h0,        1'b1};
    vt[7] = '{32'h9000_0000, 1'b1, 9'h000, 9'h000, 6'h00, 32'h0,        1'b1};

    // Reset with a master already requesting: broadcast and selects stay at zero.
    set_m(0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h3000_0010);
    @(posedge sys_clk); #1;
    push("rst_scyc", SG_CYC, 0);
    push("rst_sstb", SG_STB, 0);
    push("rst_ack",  SG_ACK, 0);
    push("rst_err",  SG_ERR, 0);
    push("rst_adr",  SG_ADR, 0);
    step();
    sys_rst = 1'b0;
    push("gnt_latency", SG_STB, 0);
    step();

    // Master 0 holds the bus; each vector is followed by a strobe-free cycle.
    for (int i = 0; i < 8; i++) begin
      set_m(0, 1'b1, 1'b1, vt[i].we, 3'b000, vt[i].adr);
      ack_vec = vt[i].ack;
      push($sformatf("v%0d_stb", i),  SG_STB,  64'(vt[i].stb));
      push($sformatf("v%0d_cyc", i),  SG_CYC,  64'(vt[i].stb));
      push($sformatf("v%0d_ack", i),  SG_ACK,  64'(vt[i].mack));
      push($sformatf("v%0d_rdat", i), SG_RDAT, 64'(vt[i].dat));
      push($sformatf("v%0d_adr", i),  SG_ADR,  64'(vt[i].adr));
      push($sformatf("v%0d_we", i),   SG_WE,   64'(vt[i].we));
      push($sformatf("v%0d_wdat", i), SG_WDAT, 64'(mdat(0, vt[i].adr)));
      push($sformatf("v%0d_err0", i), SG_ERR,  0);
      step();
      set_m(0, 1'b1, 1'b0, vt[i].we, 3'b000, vt[i].adr);
      ack_vec = '0;
      push($sformatf("v%0d_err1", i), SG_ERR, vt[i].err ? 64'h01 : 64'h00);
      push($sformatf("v%0d_stb1", i), SG_STB, 0);
      step();
    end
    idle_all(2);

    // Round-robin among masters 1, 3, 5; each drops cyc for one cycle after its ack.
    ack_auto = 1'b1;
    exp_g = '{1, 3, 5, 1};
    for (int k = 1; k < N_M; k += 2) set_m(k, 1'b1, 1'b1, 1'b0, 3'b000, 32'(k) << 28);
    down = -1;
    for (int c = 0; c < 30 && exp_g.size() > 0; c++) begin
      acked = -1;
      @(negedge sys_clk);
      if (m_ack_o != '0) begin
        cmp("rr_order", 64'(m_ack_o), 64'(1) << exp_g.pop_front());
        for (int k = 0; k < N_M; k++) if (m_ack_o[k]) acked = k;
      end
      @(posedge sys_clk); #1;
      if (down >= 0) set_m(down, 1'b1, 1'b1, 1'b0, 3'b000, 32'(down) << 28);
      down = acked;
      if (acked >= 0) set_m(acked, 1'b0, 1'b0, 1'b0, 3'b000, 32'(acked) << 28);
    end
    if (exp_g.size() > 0) cmp("rr_timeout", 64'(exp_g.size()), 0);
    idle_all(2);

    // Burst lock: master 2 keeps the grant for 4 beats while master 0 waits.
    exp_g = '{4, 4, 4, 4, 1};
    beats = 0;
    set_m(2, 1'b1, 1'b1, 1'b0, 3'b010, 32'h2000_0000);
    for (int c = 0; c < 30 && exp_g.size() > 0; c++) begin
      @(negedge sys_clk);
      if (m_ack_o != '0) begin
        cmp("burst_gnt", 64'(m_ack_o), 64'(exp_g.pop_front()));
        if (m_ack_o[2]) begin
          beats++;
          cmp("burst_cti", 64'(s_cti_o), 64'(3'b010));
        end
      end
      @(posedge sys_clk); #1;
      if (c == 0) set_m(0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0000);
      if (beats >= 4) set_m(2, 1'b0, 1'b0, 1'b0, 3'b000, 32'h2000_0000);
    end
    if (exp_g.size() > 0) cmp("burst_timeout", 64'(exp_g.size()), 0);
    idle_all(2);

    // Slave 1 never acks: err exactly 8 cycles after WAIT entry, stb masked then.
    ack_auto = 1'b0;
    ack_vec  = '0;
    set_m(4, 1'b1, 1'b1, 1'b0, 3'b000, 32'h1000_0000);
    for (int c = 0; c < 12; c++) begin
      push($sformatf("to%0d_err", c), SG_ERR, (c == 10) ? 64'h10 : 64'h00);
      push($sformatf("to%0d_stb", c), SG_STB, (c == 0 || c == 10) ? 64'h000 : 64'h002);
      step();
    end
    idle_all(2);

    // Reset during beat 2 of a burst; pointer must restart so master 0 wins.
    ack_auto = 1'b1;
    set_m(2, 1'b1, 1'b1, 1'b0, 3'b010, 32'h2000_0000);
    set_m(3, 1'b1, 1'b1, 1'b0, 3'b000, 32'h3000_0000);
    step();
    push("rb_beat1", SG_ACK, 64'h04);
    step();
    sys_rst = 1'b1;
    push("rb_beat2", SG_ACK, 64'h04);
    step();
    sys_rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0000);
    push("rb_stb",  SG_STB, 0);
    push("rb_cyc",  SG_CYC, 0);
    push("rb_ack",  SG_ACK, 0);
    push("rb_err",  SG_ERR, 0);
    push("rb_adr",  SG_ADR, 0);
    step();
    push("rb_first", SG_ACK, 64'h01);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
